// File: rtl/multi_hdr_parser_pkg.sv
// Shared definitions for the multi-header parser: FSM encoding, next-table
// entry layout and the "no next header" marker.
package multi_hdr_parser_pkg;

    localparam int NEXT_ID_W = 16;
    localparam logic [NEXT_ID_W-1:0] NO_NEXT_ID = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VISIT,
        ST_REQ,
        ST_WAIT,
        ST_SCAN,
        ST_DONE,
        ST_ERR
    } state_e;

    // Bit position of next-table entry k; entry 0 sits in the most significant slot.
    function automatic int ent_lsb(input int k, input int num_next, input int ent_w);
        return (num_next - 1 - k) * ent_w;
    endfunction

endpackage

// File: rtl/multi_hdr_parser_hdr_cfg_table.sv
// Per-header configuration register file: one write port, one combinational
// read port addressed by the header id currently being parsed.
module multi_hdr_parser_hdr_cfg_table
    import multi_hdr_parser_pkg::*;
#(
    parameter int NUM_HDR  = 8,
    parameter int HDR_ID_W = 3,
    parameter int NUM_NEXT = 4,
    parameter int TAG_W    = 16,
    parameter int OFF_W    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  we_i,
    input  logic [HDR_ID_W-1:0]                   wr_id_i,
    input  logic [OFF_W-1:0]                      wr_hdr_len_i,
    input  logic [OFF_W-1:0]                      wr_tag_start_i,
    input  logic [2:0]                            wr_tag_len_i,
    input  logic [NUM_NEXT*(TAG_W+NEXT_ID_W)-1:0] wr_next_tbl_i,
    input  logic [HDR_ID_W-1:0]                   rd_id_i,
    output logic [OFF_W-1:0]                      rd_hdr_len_o,
    output logic [OFF_W-1:0]                      rd_tag_start_o,
    output logic [2:0]                            rd_tag_len_o,
    output logic [NUM_NEXT*(TAG_W+NEXT_ID_W)-1:0] rd_next_tbl_o
);

    localparam int TBL_W = NUM_NEXT * (TAG_W + NEXT_ID_W);
    localparam logic [TBL_W-1:0] TBL_RST = {NUM_NEXT{{TAG_W{1'b0}}, NO_NEXT_ID}};

    logic [OFF_W-1:0] hdr_len_q   [NUM_HDR];
    logic [OFF_W-1:0] tag_start_q [NUM_HDR];
    logic [2:0]       tag_len_q   [NUM_HDR];
    logic [TBL_W-1:0] next_tbl_q  [NUM_HDR];

    // NOTE: this small register file is reset on purpose so a fresh parser sees
    // every header as terminal with no valid next entries; large RAMs would not be.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_HDR; i++) begin
                hdr_len_q[i]   <= '0;
                tag_start_q[i] <= '0;
                tag_len_q[i]   <= '0;
                next_tbl_q[i]  <= TBL_RST;
            end
        end else if (we_i && (int'(wr_id_i) < NUM_HDR)) begin
            hdr_len_q[wr_id_i]   <= wr_hdr_len_i;
            tag_start_q[wr_id_i] <= wr_tag_start_i;
            tag_len_q[wr_id_i]   <= wr_tag_len_i;
            next_tbl_q[wr_id_i]  <= wr_next_tbl_i;
        end
    end

    assign rd_hdr_len_o   = hdr_len_q[rd_id_i];
    assign rd_tag_start_o = tag_start_q[rd_id_i];
    assign rd_tag_len_o   = tag_len_q[rd_id_i];
    assign rd_next_tbl_o  = next_tbl_q[rd_id_i];

endmodule

// File: rtl/multi_hdr_parser.sv
// Header-chain parser: walks headers from id 0, reads each next-header tag from
// memory and scans that header's next table to pick the following header.
module multi_hdr_parser
    import multi_hdr_parser_pkg::*;
#(
    parameter int NUM_HDR   = 8,
    parameter int HDR_ID_W  = $clog2(NUM_HDR),
    parameter int NUM_NEXT  = 4,
    parameter int TAG_W     = 16,
    parameter int OFF_W     = 8,
    parameter int MAX_DEPTH = 8,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic [ADDR_W-1:0]                     pkt_addr_i,
    output logic                                  ready_o,
    output logic                                  done_o,
    output logic                                  err_o,
    output logic [NUM_HDR-1:0]                    hdr_valid_o,
    output logic [NUM_HDR*OFF_W-1:0]              hdr_off_o,
    output logic                                  mem_ce_o,
    output logic                                  mem_we_o,
    output logic [ADDR_W-1:0]                     mem_addr_o,
    output logic [3:0]                            mem_width_o,
    output logic [DATA_W-1:0]                     mem_data_o,
    input  logic [DATA_W-1:0]                     mem_data_i,
    input  logic                                  cfg_we_i,
    input  logic [HDR_ID_W-1:0]                   cfg_hdr_id_i,
    input  logic [OFF_W-1:0]                      cfg_hdr_len_i,
    input  logic [OFF_W-1:0]                      cfg_tag_start_i,
    input  logic [2:0]                            cfg_tag_len_i,
    input  logic [NUM_NEXT*(TAG_W+NEXT_ID_W)-1:0] cfg_next_table_i
);

    localparam int ENT_W   = TAG_W + NEXT_ID_W;
    localparam int TBL_W   = NUM_NEXT * ENT_W;
    localparam int IDX_W   = (NUM_NEXT > 1) ? $clog2(NUM_NEXT) : 1;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        pkt_addr_q, pkt_addr_d;
    logic [HDR_ID_W-1:0]      cur_id_q, cur_id_d;
    logic [OFF_W-1:0]         cur_off_q, cur_off_d;
    logic [DEPTH_W-1:0]       depth_q, depth_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TAG_W-1:0]         tag_q, tag_d;
    logic [NUM_HDR-1:0]       hdr_valid_q, hdr_valid_d;
    logic [NUM_HDR*OFF_W-1:0] hdr_off_q, hdr_off_d;
    logic                     err_q, err_d;

    logic [OFF_W-1:0]     hdr_len, tag_start;
    logic [2:0]           tag_len;
    logic [TBL_W-1:0]     next_tbl;
    logic [ENT_W-1:0]     ent;
    logic [TAG_W-1:0]     ent_tag;
    logic [NEXT_ID_W-1:0] ent_next_id;
    logic [OFF_W:0]       off_sum;
    logic                 scan_hit, bad_id, off_ovf, visit_err, last_idx, hop_ok;

    // Config is only writable while idle, so a parse always sees a stable table.
    multi_hdr_parser_hdr_cfg_table #(
        .NUM_HDR  (NUM_HDR),
        .HDR_ID_W (HDR_ID_W),
        .NUM_NEXT (NUM_NEXT),
        .TAG_W    (TAG_W),
        .OFF_W    (OFF_W)
    ) u_cfg (
        .clk            (clk),
        .rst            (rst),
        .we_i           (cfg_we_i && (state_q == ST_IDLE)),
        .wr_id_i        (cfg_hdr_id_i),
        .wr_hdr_len_i   (cfg_hdr_len_i),
        .wr_tag_start_i (cfg_tag_start_i),
        .wr_tag_len_i   (cfg_tag_len_i),
        .wr_next_tbl_i  (cfg_next_table_i),
        .rd_id_i        (cur_id_q),
        .rd_hdr_len_o   (hdr_len),
        .rd_tag_start_o (tag_start),
        .rd_tag_len_o   (tag_len),
        .rd_next_tbl_o  (next_tbl)
    );

    assign ent         = next_tbl[ent_lsb(int'(idx_q), NUM_NEXT, ENT_W) +: ENT_W];
    assign ent_tag     = ent[ENT_W-1 -: TAG_W];
    assign ent_next_id = ent[NEXT_ID_W-1:0];
    assign scan_hit    = (ent_next_id != NO_NEXT_ID) && (ent_tag == tag_q);
    assign bad_id      = ent_next_id >= NEXT_ID_W'(NUM_HDR);
    assign off_sum     = {1'b0, cur_off_q} + {1'b0, hdr_len};
    assign off_ovf     = off_sum[OFF_W];
    assign visit_err   = hdr_valid_q[cur_id_q] || (depth_q == DEPTH_W'(MAX_DEPTH));
    assign last_idx    = idx_q == IDX_W'(NUM_NEXT - 1);
    assign hop_ok      = scan_hit && !bad_id && !off_ovf;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_VISIT;
            ST_VISIT: begin
                if (visit_err)           state_d = ST_ERR;
                else if (tag_len == 3'd0) state_d = ST_DONE;
                else                      state_d = ST_REQ;
            end
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_SCAN;
            ST_SCAN: begin
                if (scan_hit)      state_d = hop_ok ? ST_VISIT : ST_ERR;
                else if (last_idx) state_d = ST_DONE;
            end
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o     = 1'b0;
        done_o      = 1'b0;
        mem_ce_o    = 1'b0;
        mem_addr_o  = '0;
        mem_width_o = '0;
        case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_REQ: begin
                mem_ce_o    = 1'b1;
                mem_addr_o  = pkt_addr_q + ADDR_W'(cur_off_q) + ADDR_W'(tag_start);
                mem_width_o = 4'(tag_len);
            end
            ST_DONE, ST_ERR: done_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pkt_addr_d  = pkt_addr_q;
        cur_id_d    = cur_id_q;
        cur_off_d   = cur_off_q;
        depth_d     = depth_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        hdr_valid_d = hdr_valid_q;
        hdr_off_d   = hdr_off_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                pkt_addr_d  = pkt_addr_i;
                cur_id_d    = '0;
                cur_off_d   = '0;
                depth_d     = '0;
                hdr_valid_d = '0;
                hdr_off_d   = '0;
                err_d       = 1'b0;
            end
            ST_VISIT: if (!visit_err) begin
                hdr_valid_d[cur_id_q]                    = 1'b1;
                hdr_off_d[int'(cur_id_q)*OFF_W +: OFF_W] = cur_off_q;
            end
            ST_WAIT: begin
                tag_d = TAG_W'(mem_data_i);
                idx_d = '0;
            end
            ST_SCAN: begin
                if (hop_ok) begin
                    cur_off_d = off_sum[OFF_W-1:0];
                    cur_id_d  = ent_next_id[HDR_ID_W-1:0];
                    depth_d   = depth_q + DEPTH_W'(1);
                end else if (!scan_hit) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
        if (state_d == ST_ERR) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_addr_q  <= '0;
            cur_id_q    <= '0;
            cur_off_q   <= '0;
            depth_q     <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            hdr_valid_q <= '0;
            hdr_off_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            pkt_addr_q  <= pkt_addr_d;
            cur_id_q    <= cur_id_d;
            cur_off_q   <= cur_off_d;
            depth_q     <= depth_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_off_q   <= hdr_off_d;
            err_q       <= err_d;
        end
    end

    assign err_o       = err_q;
    assign hdr_valid_o = hdr_valid_q;
    assign hdr_off_o   = hdr_off_q;
    assign mem_we_o    = 1'b0;
    assign mem_data_o  = '0;

endmodule

// File: doc/multi_hdr_parser.md
Name: multi_hdr_parser

Overview:
- Parametrised next-generation header parser for the reconfigurable switch packet processor.
- Walks a packet header chain held in SRAM, starting from header id 0 at the packet base address.
- At each header it reads the next-header tag through the shared memory port. It then scans a per-header programmable next table (NUM_NEXT entries) sequentially to pick the following header.
- Produces a per-header valid bitmap plus byte offsets for the matcher. Adds loop, depth and offset-overflow detection.

Parameters:
- NUM_HDR, 8, number of header types (ids 0..NUM_HDR-1)
- HDR_ID_W, 3, width of a header id, equal to clog2(NUM_HDR)
- NUM_NEXT, 4, next-table entries per header
- TAG_W, 16, tag width in bits; maximum tag_len is TAG_W/8 bytes
- OFF_W, 8, byte-offset width relative to the packet base
- MAX_DEPTH, 8, maximum headers visited per packet
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-low reset
- start_i, in, 1, start parse; accepted only when ready_o=1
- pkt_addr_i, in, ADDR_W, packet base byte address; sampled on acceptance
- ready_o, out, 1, idle and able to accept start_i
- done_o, out, 1, one-cycle pulse when the parse ends
- err_o, out, 1, parse error flag; valid with done_o, held until the next start
- hdr_valid_o, out, NUM_HDR, bit i is set when header i was parsed
- hdr_off_o, out, NUM_HDR*OFF_W, byte offset of header i at bits [i*OFF_W +: OFF_W]
- mem_ce_o, out, 1, memory read request
- mem_we_o, out, 1, tied 0
- mem_addr_o, out, ADDR_W, read byte address
- mem_width_o, out, 4, bytes to read (1..TAG_W/8)
- mem_data_o, out, DATA_W, tied 0
- mem_data_i, in, DATA_W, read data, right-aligned, first byte most significant; valid the cycle after mem_ce_o
- cfg_we_i, in, 1, write one header config entry
- cfg_hdr_id_i, in, HDR_ID_W, entry index
- cfg_hdr_len_i, in, OFF_W, header length in bytes
- cfg_tag_start_i, in, OFF_W, tag byte offset within the header
- cfg_tag_len_i, in, 3, tag length in bytes; 0 marks a terminal header
- cfg_next_table_i, in, NUM_NEXT*(TAG_W+16), entry k = {tag, next_id[15:0]}; entry 0 is the most significant

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; ready_o=1.
  - done_o, err_o, mem_ce_o and hdr_valid_o are cleared to 0; hdr_off_o is cleared to 0.
  - The config table is cleared: hdr_len=0, tag_len=0, every next_id=16'hFFFF.
  - Reset mid-parse aborts immediately; no done_o pulse is produced.
- Config writes:
  - Applied on the clk edge only in IDLE.
  - Writes while busy are dropped.
  - A write coincident with start_i is applied; the parse uses the new value.
- FSM:
  - IDLE: on start_i, latch pkt_addr_i; set cur_id=0, cur_off=0, depth=0; clear hdr_valid_o and err_o; go to VISIT.
  - VISIT, checked in this order:
    - hdr_valid[cur_id] already set (loop) goes to ERR.
    - depth==MAX_DEPTH goes to ERR.
    - Otherwise set hdr_valid[cur_id] and off[cur_id]=cur_off.
    - Then tag_len==0 goes to DONE; otherwise go to REQ.
  - REQ: for one cycle drive mem_ce_o=1, mem_addr_o=pkt_addr+cur_off+tag_start, mem_width_o=tag_len. Go to WAIT.
  - WAIT: capture the tag as mem_data_i zero-extended/truncated to TAG_W; idx=0; go to SCAN.
  - SCAN: one entry per cycle.
    - Entry idx matches when next_id!=16'hFFFF and the entry tag equals the captured tag.
    - On a match:
      - next_id>=NUM_HDR goes to ERR.
      - cur_off+hdr_len overflowing OFF_W bits goes to ERR.
      - Otherwise set cur_off+=hdr_len, cur_id=next_id, depth++, and go to VISIT.
    - No match at idx=NUM_NEXT-1 goes to DONE. An unknown tag ends the parse without error.
  - DONE: done_o=1 for one cycle; back to IDLE.
  - ERR: done_o=1 and err_o=1 for one cycle; back to IDLE. err_o stays held.
- Outputs:
  - hdr_valid_o and hdr_off_o hold until the next accepted start.
  - mem_addr_o and mem_width_o are 0 when mem_ce_o=0.
- ready_o is 1 only in IDLE; start_i is ignored otherwise.
- Latency: a single terminal header gives done_o 2 cycles after the acceptance edge. Each hop costs 3 cycles (VISIT/REQ/WAIT) plus (matched idx+1) SCAN cycles.

Decomposition:
- Shared def header additions:
  - NO_NEXT_ID = 16'hFFFF.
  - FSM state encodings: IDLE, VISIT, REQ, WAIT, SCAN, DONE, ERR.
  - Next-table entry field-slice macros.
- Sub-module hdr_cfg_table: NUM_HDR-deep register file with a write port and a combinational read by cur_id, returning hdr_len, tag_start, tag_len and the next table.

Test Plan:
- Single chain:
  - Config: hdr0 {len14, tag_start 12, tag_len 2, entry0 {0x0800, 1}}; hdr1 {len20, tag_len 0}.
  - Stimulus: packet at address 4 with bytes 12-13 = 08 00.
  - Required response: hdr_valid=0b00000011, off0=0, off1=14, err=0, done_o 6 cycles after acceptance; one read at addr 16, width 2.
- Unknown tag:
  - Stimulus: same config with bytes 12-13 = 86 DD.
  - Required response: hdr_valid=0b00000001, err=0, done_o after 4 SCAN cycles.
- Loop:
  - Stimulus: hdr1 entry0 {0x06, 0}, tag_len 1, tag byte 06.
  - Required response: err_o=1, hdr_valid=0b00000011.
- Overflow and invalid id:
  - Stimulus A: hdr0 len 250, chain to hdr1 len 10, then a hop.
  - Stimulus B: next_id=9.
  - Required response: err_o=1 in both cases.
- Busy and reset:
  - Stimulus: start_i and cfg_we_i while in SCAN.
  - Required response: both ignored.
  - Stimulus: rst=0 mid-parse.
  - Required response: ready_o=1, outputs cleared, no done_o pulse, config table cleared.
